uart_tx_fifo: RTL

Buffered 8N1 serial transmitter downstream of the RV32IM core's UART MMIO port. The core emits `{valid, byte}` for one cycle per store to 0xfff0 and never stalls, so this block queues bytes in a small FIFO and serialises them onto a single TX line at a fixed baud divisor. It also exports the occupancy and full status that a later core revision will map onto the UART flag at 0xfff1.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line levels, MMIO addresses, strobe payload.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [31:0] UART_MMIO_ADDR = 32'h0000_fff0;
  localparam logic [31:0] UART_MMIO_FLAG = 32'h0000_fff1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Strobe-plus-byte word driven by the core's UART MMIO port.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } uart_mmio_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO; occupancy tracked by a counter so wrapped pointers never alias full/empty.
module uart_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata_c,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_d;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata_c = mem[rd_ptr];

  // Next occupancy.
  always_comb begin
    count_d = count;
    if (do_push && !do_pop) begin
      count_d = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count - CW'(1);
    end
  end

  // Storage array, contents not reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and registered status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 transmitter: queues MMIO byte strobes and serialises them LSB first.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = 16,
  parameter  int unsigned FIFO_DEPTH   = 16,
  localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [8:0]    uart_in,
  output logic          tx,
  output logic          tx_busy,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full,
  output logic          overflow
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  uart_mmio_t        req;
  uart_state_e       state_q;
  uart_state_e       state_d;
  logic [BW-1:0]     baud_q;
  logic [BW-1:0]     baud_d;
  logic [2:0]        bit_q;
  logic [2:0]        bit_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              tx_d;
  logic              pop_c;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign req = uart_mmio_t'(uart_in);

  uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (req.valid),
    .wdata   (req.data),
    .pop     (pop_c),
    .rdata_c (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencing; STOP chains straight into START when more bytes are waiting.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = BAUD_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          bit_d   = 3'd0;
          baud_d  = BAUD_LOAD;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_rdata;
            baud_d  = BAUD_LOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the upcoming cycle.
  always_comb begin
    tx_d = STOP_BIT;
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      default: tx_d = STOP_BIT;
    endcase
  end

  // FSM, baud counter, shift register and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= '0;
      tx       <= STOP_BIT;
      tx_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx       <= tx_d;
      tx_busy  <= (state_d != IDLE);
      overflow <= overflow | (req.valid & fifo_full & ~pop_c);
    end
  end

endmodule
